// File: rtl/instr_fetch_stage.sv
// Fetch-stage datapath: program counter, synchronous instruction RAM and
// the fetch stage register. The fetch controller drives it through strobes.
//
// Ports
//   clk, reset             clock and asynchronous active-high reset
//   InstrRAMenable         RAM chip enable
//   InstrRAMread_en        RAM read strobe (read needs both enables high)
//   PCounterIncb_in        PC update strobe
//   PCounterInccontrol_in  PC source: 0 = pc+1, 1 = br_target
//   StageRegld_str         stage register load strobe
//   br_target              branch target address
//   prog_we/addr/data      program-load write port into the RAM
//   instr_ack              downstream consumed the current instruction
//   pc                     current program counter
//   instr/opcode/operand   latched instruction and its fields
//   instr_pc               address the latched instruction came from
//   instr_valid            stage register holds an unconsumed instruction
//   overrun                sticky: a load overwrote an unconsumed instruction
module instr_fetch_stage #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              InstrRAMenable,
  input  logic              InstrRAMread_en,
  input  logic              PCounterIncb_in,
  input  logic              PCounterInccontrol_in,
  input  logic              StageRegld_str,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              instr_ack,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [3:0]        opcode,
  output logic [DATA_W-5:0] operand,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              overrun
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // RAM contents survive reset, so the array has no reset branch.
  logic [DATA_W-1:0] mem [Depth];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ram_q, ram_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              rd_en;

  assign rd_en = InstrRAMenable & InstrRAMread_en;

  // Write port. Non-blocking update gives read-first behaviour against a
  // same-edge read of the same address.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (PCounterIncb_in) begin
      pc_d = PCounterInccontrol_in ? br_target : pc_q + 1'b1;
    end
  end

  // Read uses the pre-edge pc, so a same-edge PC update does not affect it.
  always_comb begin
    ram_d     = ram_q;
    rd_addr_d = rd_addr_q;
    if (rd_en) begin
      ram_d     = mem[pc_q];
      rd_addr_d = pc_q;
    end
  end

  always_comb begin
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    if (StageRegld_str) begin
      instr_d    = ram_q;
      instr_pc_d = rd_addr_q;
      valid_d    = 1'b1;
      // A same-edge ack means the old instruction was consumed, not lost.
      if (valid_q && !instr_ack) begin
        overrun_d = 1'b1;
      end
    end else if (instr_ack) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= '0;
      ram_q      <= '0;
      rd_addr_q  <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ram_q      <= ram_d;
      rd_addr_q  <= rd_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[DATA_W-1 -: 4];
  assign operand     = instr_q[DATA_W-5:0];
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios with literal
// expectations, then randomized strobes checked every cycle against a
// behavioural model of the fetch datapath.
module tb_instr_fetch_stage;

  logic        clk;
  logic        reset;
  logic        en, rd, inc, ctl, ld, ack;
  logic [7:0]  tgt;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_stage #(
    .ADDR_W(8),
    .DATA_W(16)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .InstrRAMenable       (en),
    .InstrRAMread_en      (rd),
    .PCounterIncb_in      (inc),
    .PCounterInccontrol_in(ctl),
    .StageRegld_str       (ld),
    .br_target            (tgt),
    .prog_we              (prog_we),
    .prog_addr            (prog_addr),
    .prog_data            (prog_data),
    .instr_ack            (ack),
    .pc                   (pc),
    .instr                (instr),
    .opcode               (opcode),
    .operand              (operand),
    .instr_pc             (instr_pc),
    .instr_valid          (instr_valid),
    .overrun              (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_mem [256];
  int m_pc, m_ram, m_raddr, m_instr, m_ipc, m_valid, m_ovr;

  always @(posedge clk) begin
    if (prog_we) m_mem[prog_addr] <= int'(prog_data);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 0; m_ram <= 0; m_raddr <= 0;
      m_instr <= 0; m_ipc <= 0; m_valid <= 0; m_ovr <= 0;
    end else begin
      if (en && rd) begin
        m_ram   <= m_mem[m_pc];
        m_raddr <= m_pc;
      end
      if (inc) m_pc <= ctl ? int'(tgt) : (m_pc + 1) % 256;
      if (ld) begin
        m_instr <= m_ram;
        m_ipc   <= m_raddr;
        m_valid <= 1;
        if (m_valid == 1 && !ack) m_ovr <= 1;
      end else if (ack) begin
        m_valid <= 0;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp[31:0]) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    cmp("pc", 32'(pc), m_pc);
    cmp("instr", 32'(instr), m_instr);
    cmp("opcode", 32'(opcode), m_instr / 4096);
    cmp("operand", 32'(operand), m_instr % 4096);
    cmp("instr_pc", 32'(instr_pc), m_ipc);
    cmp("instr_valid", 32'(instr_valid), m_valid);
    cmp("overrun", 32'(overrun), m_ovr);
  end

  // ---------------- stimulus helpers ----------------
  // Called 2 time units after a rising edge; returns the same distance after the next.
  task automatic step(input logic r, input logic i, input logic c, input logic [7:0] t,
                      input logic l, input logic a);
    en = r; rd = r; inc = i; ctl = c; tgt = t; ld = l; ack = a;
    @(posedge clk);
    #2;
    en = 0; rd = 0; inc = 0; ctl = 0; ld = 0; ack = 0;
  endtask

  task automatic prog(input logic [7:0] a, input logic [15:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    @(posedge clk);
    #2;
    prog_we = 0;
  endtask

  initial begin
    reset = 1; en = 0; rd = 0; inc = 0; ctl = 0; ld = 0; ack = 0; tgt = 0;
    prog_we = 0; prog_addr = 0; prog_data = 0;
    @(posedge clk);
    #2;
    cmp("reset_pc", 32'(pc), 0);
    cmp("reset_valid", 32'(instr_valid), 0);

    // Preload the whole RAM while reset is held.
    for (int a = 0; a < 256; a++) prog(8'(a), 16'($urandom));
    prog(8'h00, 16'h1001);
    prog(8'h01, 16'h2002);
    prog(8'h02, 16'h3003);
    prog(8'h03, 16'h4004);
    prog(8'h05, 16'h1111);
    prog(8'hFF, 16'hABCD);
    reset = 0;

    // read -> load -> inc, ack held every cycle
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1, 1);
      cmp("seq_instr", 32'(instr), 32'h1001 * (k + 1) + 0);
      cmp("seq_instr_pc", 32'(instr_pc), k);
      cmp("seq_opcode", 32'(opcode), k + 1);
      cmp("seq_valid", 32'(instr_valid), 1);
      step(0, 1, 0, 0, 0, 1);
    end
    cmp("seq_pc_end", 32'(pc), 3);
    cmp("seq_no_overrun", 32'(overrun), 0);

    // Wrap and read of the last address with a same-edge PC update.
    step(0, 1, 1, 8'hFF, 0, 0);
    cmp("pc_ff", 32'(pc), 32'hFF);
    step(1, 1, 0, 0, 0, 0);
    cmp("pc_wrap", 32'(pc), 0);
    step(0, 0, 0, 0, 1, 0);
    cmp("wrap_instr", 32'(instr), 32'hABCD);
    cmp("wrap_instr_pc", 32'(instr_pc), 32'hFF);

    // Load and ack on the same edge while valid.
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    cmp("ldack_instr", 32'(instr), 32'h1001);
    cmp("ldack_valid", 32'(instr_valid), 1);
    cmp("ldack_overrun", 32'(overrun), 0);

    // Two loads without ack.
    step(0, 0, 0, 0, 0, 1);
    cmp("ack_clears", 32'(instr_valid), 0);
    step(0, 0, 0, 0, 0, 1);
    cmp("ack_idle_ignored", 32'(instr_valid), 0);
    step(1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    cmp("ovr_first", 32'(overrun), 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    cmp("ovr_instr", 32'(instr), 32'h2002);
    cmp("ovr_valid", 32'(instr_valid), 1);
    cmp("ovr_set", 32'(overrun), 1);

    // Read-first on a same-edge write to the read address.
    step(0, 1, 1, 8'h05, 0, 1);
    prog_we = 1; prog_addr = 8'h05; prog_data = 16'h5555;
    step(1, 0, 0, 0, 0, 0);
    prog_we = 0;
    step(0, 0, 0, 0, 1, 0);
    cmp("rdfirst_old", 32'(instr), 32'h1111);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    cmp("rdfirst_new", 32'(instr), 32'h5555);
    cmp("ovr_sticky", 32'(overrun), 1);

    // Reset between read and load edges.
    step(0, 1, 1, 8'h00, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    reset = 1;
    #1;
    cmp("arst_pc", 32'(pc), 0);
    cmp("arst_instr", 32'(instr), 0);
    cmp("arst_opcode", 32'(opcode), 0);
    cmp("arst_operand", 32'(operand), 0);
    cmp("arst_instr_pc", 32'(instr_pc), 0);
    cmp("arst_valid", 32'(instr_valid), 0);
    cmp("arst_overrun", 32'(overrun), 0);
    @(posedge clk);
    #2;
    reset = 0;
    step(0, 0, 0, 0, 1, 0);
    cmp("arst_discard", 32'(instr), 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    cmp("arst_mem_kept", 32'(instr), 32'h1001);

    // Randomized strobes, including program writes and rare mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = 8'($urandom);
      prog_data = 16'($urandom);
      en = 1'($urandom); rd = 1'($urandom); inc = 1'($urandom);
      ctl = ($urandom_range(0, 3) == 0); tgt = 8'($urandom);
      ld = 1'($urandom); ack = 1'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        #2;
        reset = 0;
      end
      @(posedge clk);
      #2;
    end
    prog_we = 0; en = 0; rd = 0; inc = 0; ld = 0; ack = 0;
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
